// File: rtl/sp1_pkg.sv
// Shared definitions for the SP1 SPI slave (sp1_s) and master (sp1_m):
// FSM state encoding and the default frame width.
package sp1_pkg;

    // Default frame length in bits.
    localparam int SP1_DATA_W = 8;

    // Default synchronizer depth for the asynchronous SPI pins.
    localparam int SP1_SYNC_STAGES = 2;

    // Frame sequencing states shared by master and slave.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sp1_state_t;

endpackage

// File: rtl/sp1_sync.sv
// Multi-flop synchronizer for one asynchronous input bit.
// SYNC_STAGES flops in series, all cleared by the async reset.
module sp1_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw input through the flop chain; the last stage is the safe copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/sp1_s.sv
// SP1 SPI slave, mode 0 (sp_clk idles low, data sampled on rising edge,
// shifted on falling edge), MSB first, oversampled by the system clock.
// Optional feature: define SP1_S_OVERRUN_EN to add the s_rd_ack input and
// the overrun output that flags a received byte lost before it was read.
module sp1_s
    import sp1_pkg::*;
#(
    parameter int DATA_W      = SP1_DATA_W,
    parameter int SYNC_STAGES = SP1_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SP1_S_OVERRUN_EN
    input  logic              s_rd_ack,
    output logic              overrun,
`endif
    input  logic              sp_clk,
    input  logic              ss,
    input  logic              mosi,
    input  logic [DATA_W-1:0] s_data_send,
    output logic              miso,
    output logic              busy_s,
    output logic [DATA_W-1:0] s_rece,
    output logic              s_valid
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // Synchronized copies of the SPI pins and their one-cycle-delayed history.
    logic sclk_s;
    logic ss_s;
    logic mosi_s;
    logic sclk_prev;
    logic ss_prev;

    logic sclk_rise;
    logic sclk_fall;
    logic ss_fall;

    // Frame state and datapath registers with their next values.
    sp1_state_t        state;
    sp1_state_t        state_n;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] tx_n;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] rx_n;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [DATA_W-1:0] rece_n;
    logic              valid_n;

    sp1_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk (clk),
        .rst (rst),
        .d   (sp_clk),
        .q   (sclk_s)
    );

    sp1_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk (clk),
        .rst (rst),
        .d   (ss),
        .q   (ss_s)
    );

    sp1_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk (clk),
        .rst (rst),
        .d   (mosi),
        .q   (mosi_s)
    );

    // Remember last cycle's synchronized sp_clk and ss for edge detection.
    // ss history resets low so a select held low through reset is not
    // mistaken for a fresh falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b0;
        end else begin
            sclk_prev <= sclk_s;
            ss_prev   <= ss_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign ss_fall   = ~ss_s & ss_prev;

    // State and datapath register bank; everything is decided in the next-state logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            s_rece  <= '0;
            s_valid <= 1'b0;
        end else begin
            state   <= state_n;
            tx_sr   <= tx_n;
            rx_sr   <= rx_n;
            bit_cnt <= cnt_n;
            s_rece  <= rece_n;
            s_valid <= valid_n;
        end
    end

    // Frame sequencing: load on select, sample on rising sp_clk, shift on falling
    // sp_clk, publish the byte for one cycle, then chain or return to idle.
    // A falling edge only shifts after the first rising edge of the frame, so the
    // trailing falling edge of the previous frame never eats the freshly loaded MSB.
    always_comb begin
        state_n = state;
        tx_n    = tx_sr;
        rx_n    = rx_sr;
        cnt_n   = bit_cnt;
        rece_n  = s_rece;
        valid_n = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (ss_fall) begin
                    tx_n    = s_data_send;
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ss_s) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else if (sclk_rise) begin
                    rx_n  = {rx_sr[DATA_W-2:0], mosi_s};
                    cnt_n = bit_cnt + CNT_W'(1);
                    if (bit_cnt == LAST_BIT) begin
                        state_n = ST_DONE;
                    end
                end else if (sclk_fall && (bit_cnt != '0)) begin
                    tx_n = {tx_sr[DATA_W-2:0], 1'b0};
                end
            end
            ST_DONE: begin
                rece_n  = rx_sr;
                valid_n = 1'b1;
                cnt_n   = '0;
                if (!ss_s) begin
                    tx_n    = s_data_send;
                    state_n = ST_SHIFT;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    assign miso   = ~ss_s & tx_sr[DATA_W-1];
    assign busy_s = (state != ST_IDLE) & ~ss_s;

`ifdef SP1_S_OVERRUN_EN
    logic unread;

    // Track whether the last published byte has been acknowledged; a new byte
    // arriving on top of an unacknowledged one raises overrun until the next ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unread  <= 1'b0;
            overrun <= 1'b0;
        end else if (state == ST_DONE) begin
            unread <= 1'b1;
            if (unread && !s_rd_ack) begin
                overrun <= 1'b1;
            end else if (s_rd_ack) begin
                overrun <= 1'b0;
            end
        end else if (s_rd_ack) begin
            unread  <= 1'b0;
            overrun <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sp1_s.sv
// Self-checking bench for the SP1 SPI slave: a table of single frames plus
// hand-written back-to-back, abort, reset and mid-frame update sequences.
// Define SP1_S_OVERRUN_EN to also exercise the overrun flag.
module tb_sp1_s;

    localparam int DATA_W = 8;
    localparam int SYNC   = 2;
    localparam int HALF   = 6;
    localparam int LAT    = SYNC + 2;

    logic             clk;
    logic             rst;
    logic             sp_clk;
    logic             ss;
    logic             mosi;
    logic [DATA_W-1:0] s_data_send;
    logic             miso;
    logic             busy_s;
    logic [DATA_W-1:0] s_rece;
    logic             s_valid;
`ifdef SP1_S_OVERRUN_EN
    logic             s_rd_ack;
    logic             overrun;
`endif

    int vec_count  = 0;
    int fail_count = 0;

    int   valid_cnt   = 0;
    int   wide_pulses = 0;
    logic valid_prev  = 1'b0;
    logic [DATA_W-1:0] rece_q[$];

    typedef struct {
        logic [7:0] mo;
        logic [7:0] send;
        logic [7:0] exp_rece;
        logic [7:0] exp_mi;
    } vec_t;

    vec_t vecs[5];

    sp1_s #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef SP1_S_OVERRUN_EN
        .s_rd_ack    (s_rd_ack),
        .overrun     (overrun),
`endif
        .sp_clk      (sp_clk),
        .ss          (ss),
        .mosi        (mosi),
        .s_data_send (s_data_send),
        .miso        (miso),
        .busy_s      (busy_s),
        .s_rece      (s_rece),
        .s_valid     (s_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every s_valid pulse, the byte it published, and any pulse wider than one cycle.
    always @(negedge clk) begin
        if (s_valid) begin
            valid_cnt++;
            rece_q.push_back(s_rece);
            if (valid_prev) wide_pulses++;
        end
        valid_prev = s_valid;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkRange(input string name, input int act, input int lo, input int hi);
        vec_count++;
        if (act < lo || act > hi) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Master side of nbits of a mode-0 frame; optionally changes s_data_send
    // before bit chg_at. Returns the bits sampled on miso and the number of clk
    // cycles from the final rising sp_clk to s_valid, left at 0 when no pulse occurs.
    task automatic shift_byte(input logic [7:0] mo, input int nbits, input int chg_at,
                              input logic [7:0] chg_val, output logic [7:0] mi, output int lat);
        mi  = '0;
        lat = 0;
        for (int b = 0; b < nbits; b++) begin
            if (b == chg_at) s_data_send = chg_val;
            mosi = mo[7-b];
            tick(HALF);
            mi[7-b] = miso;
            sp_clk = 1'b1;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge clk);
                if (s_valid && lat == 0) lat = k;
            end
            sp_clk = 1'b0;
        end
    endtask

    task automatic applyStimulus(input vec_t v, output logic [7:0] mi, output int lat);
        s_data_send = v.send;
        ss = 1'b0;
        shift_byte(v.mo, 8, -1, 8'h00, mi, lat);
        tick(HALF);
        ss = 1'b1;
        tick(HALF);
    endtask

    initial begin
        logic [7:0] mi;
        logic [7:0] mi2;
        int         lat;
        int         v0;
        int         n;

        vecs[0] = '{8'hAB, 8'h61, 8'hAB, 8'h61};
        vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[3] = '{8'h5A, 8'hA5, 8'h5A, 8'hA5};
        vecs[4] = '{8'h80, 8'h01, 8'h80, 8'h01};

        rst         = 1'b1;
        sp_clk      = 1'b0;
        ss          = 1'b1;
        mosi        = 1'b0;
        s_data_send = '0;
`ifdef SP1_S_OVERRUN_EN
        s_rd_ack    = 1'b0;
`endif
        tick(3);
        checkOutput("reset_miso", miso, 0);
        checkOutput("reset_busy", busy_s, 0);
        checkOutput("reset_valid", s_valid, 0);
        checkOutput("reset_rece", s_rece, 0);
        rst = 1'b0;
        tick(HALF);

        $display("[TB] single frames from table");
        for (int i = 0; i < 5; i++) begin
            v0 = valid_cnt;
            applyStimulus(vecs[i], mi, lat);
            checkOutput("frame_rece", s_rece, vecs[i].exp_rece);
            checkOutput("frame_miso_byte", mi, vecs[i].exp_mi);
            checkOutput("frame_valid_pulses", valid_cnt - v0, 1);
            checkOutput("frame_valid_latency", lat, LAT);
            checkOutput("idle_miso", miso, 0);
            checkOutput("idle_busy", busy_s, 0);
        end

        $display("[TB] back-to-back frames");
        s_data_send = 8'h12;
        rece_q.delete();
        v0 = valid_cnt;
        ss = 1'b0;
        shift_byte(8'h45, 8, 4, 8'h34, mi, lat);
        shift_byte(8'h3C, 8, -1, 8'h00, mi2, lat);
        tick(HALF);
        ss = 1'b1;
        tick(HALF);
        checkOutput("b2b_miso_first", mi, 8'h12);
        checkOutput("b2b_miso_second", mi2, 8'h34);
        checkOutput("b2b_valid_pulses", valid_cnt - v0, 2);
        checkOutput("b2b_rece_count", rece_q.size(), 2);
        if (rece_q.size() >= 2) begin
            checkOutput("b2b_rece_first", rece_q[0], 8'h45);
            checkOutput("b2b_rece_second", rece_q[1], 8'h3C);
        end
        checkOutput("b2b_rece_final", s_rece, 8'h3C);

        $display("[TB] abort after 4 bits");
        s_data_send = 8'h55;
        v0 = valid_cnt;
        ss = 1'b0;
        shift_byte(8'hF0, 4, -1, 8'h00, mi, lat);
        checkOutput("abort_busy_before", busy_s, 1);
        ss = 1'b1;
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (!busy_s) begin
                n = k;
                break;
            end
        end
        checkRange("abort_busy_drop_cycles", n, 1, SYNC + 1);
        tick(HALF);
        checkOutput("abort_no_valid", valid_cnt - v0, 0);
        checkOutput("abort_rece_kept", s_rece, 8'h3C);

        $display("[TB] reset mid-frame");
        s_data_send = 8'hFF;
        ss = 1'b0;
        shift_byte(8'h3C, 5, -1, 8'h00, mi, lat);
        checkOutput("prerst_miso", miso, 1);
        checkOutput("prerst_busy", busy_s, 1);
        rst = 1'b1;
        #1;
        checkOutput("rst_miso", miso, 0);
        checkOutput("rst_busy", busy_s, 0);
        checkOutput("rst_valid", s_valid, 0);
        checkOutput("rst_rece", s_rece, 0);
        tick(2);
        rst = 1'b0;
        tick(8);
        checkOutput("rst_no_restart_busy", busy_s, 0);
        ss = 1'b1;
        tick(HALF);
        v0 = valid_cnt;
        applyStimulus('{8'hA5, 8'h3C, 8'hA5, 8'h3C}, mi, lat);
        checkOutput("postrst_rece", s_rece, 8'hA5);
        checkOutput("postrst_miso_byte", mi, 8'h3C);
        checkOutput("postrst_valid_pulses", valid_cnt - v0, 1);

        $display("[TB] s_data_send changed mid-frame");
        s_data_send = 8'h61;
        ss = 1'b0;
        shift_byte(8'hC3, 8, 4, 8'hFF, mi, lat);
        tick(HALF);
        ss = 1'b1;
        tick(HALF);
        checkOutput("midchg_miso_byte", mi, 8'h61);
        checkOutput("midchg_rece", s_rece, 8'hC3);

`ifdef SP1_S_OVERRUN_EN
        $display("[TB] overrun flag");
        s_rd_ack = 1'b1;
        tick(1);
        s_rd_ack = 1'b0;
        tick(1);
        checkOutput("ovr_cleared_start", overrun, 0);
        applyStimulus('{8'h11, 8'h22, 8'h11, 8'h22}, mi, lat);
        checkOutput("ovr_after_one", overrun, 0);
        applyStimulus('{8'h33, 8'h44, 8'h33, 8'h44}, mi, lat);
        checkOutput("ovr_after_two", overrun, 1);
        s_rd_ack = 1'b1;
        tick(1);
        s_rd_ack = 1'b0;
        tick(1);
        checkOutput("ovr_after_ack", overrun, 0);
`endif

        checkOutput("valid_pulse_width", wide_pulses, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
        $finish;
    end

endmodule
